// File: rtl/game_pkg.sv
// Shared definitions for the disappearing-piece tic-tac-toe datapath:
// cell and game-state codes, sequencer states, the winning-line table and
// a grid cell accessor.
package game_pkg;

    // Cell encoding inside the 18-bit grid (cell i lives at [2i+1:2i]).
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_X     = 2'b10;

    // Externally visible game phase.
    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_OVER = 2'b10;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Turn sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_OVER   = 3'd4
    } fsm_state_t;

    // Rows, columns, then the two diagonals, as cell-index triples.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Returns the code of cell idx; indices outside 0..8 read as empty so
    // callers never index past the grid.
    function automatic logic [1:0] cell_at(input logic [17:0] grid, input logic [3:0] idx);
        cell_at = CELL_EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i)) begin
                cell_at = grid[2*i +: 2];
            end
        end
    endfunction

endpackage

// File: rtl/win_detect.sv
// Combinational three-in-a-row detector for one symbol. Shared with the
// display and scoring blocks, so it knows nothing about whose turn it is.
module win_detect
    import game_pkg::*;
(
    input  logic [17:0] grid,
    input  logic [1:0]  sym,
    output logic        win
);

    // Any of the eight lines fully occupied by sym is a win.
    always_comb begin
        win = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if ((cell_at(grid, WIN_LINES[l][0]) == sym) &&
                (cell_at(grid, WIN_LINES[l][1]) == sym) &&
                (cell_at(grid, WIN_LINES[l][2]) == sym)) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer for disappearing-piece tic-tac-toe. Validates one move
// request at a time, issues a single-cycle mark to the recorder, waits for
// the grid to reflect it, checks the mover for a win and passes the turn.
//
// Interface protocol: there is no valid/ready back-pressure. start and
// move_req are single-cycle request pulses sampled on every rising clk edge;
// the controller never stalls them. A move_req that arrives while no move
// can be taken (settling, checking, game over, idle) is dropped silently.
// mark, grid_clr, move_err and timeout are single-cycle registered result
// pulses; position, whosTurn, winner and game_state are registered levels.
// fsm_state exposes the internal sequencer state for observation.
module turn_controller
    import game_pkg::*;
#(
    parameter int TURN_TIMEOUT = 30_000_000,
    parameter int TW           = 25,
    parameter int SETTLE_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_req,
    input  logic [3:0]  move_pos,
    input  logic [17:0] grid,
    output logic [1:0]  game_state,
    output logic        whosTurn,
    output logic [1:0]  mark,
    output logic [3:0]  position,
    output logic        grid_clr,
    output logic        move_err,
    output logic        timeout,
    output logic [1:0]  winner,
    output fsm_state_t  fsm_state
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TURN_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    logic [TW-1:0] timer;
    logic [SW-1:0] settle_cnt;
    logic [1:0]    mover_sym;
    logic          move_ok;
    logic          mover_wins;

    // Symbol of the player to move: X=10 when whosTurn=1, O=01 otherwise.
    assign mover_sym = {whosTurn, ~whosTurn};

    // A move is legal only for an on-board cell that is currently empty.
    assign move_ok = (move_pos <= 4'd8) && (cell_at(grid, move_pos) == CELL_EMPTY);

    // Only the mover is tested: a removed opponent piece can never hand the
    // opponent a win during someone else's turn.
    win_detect u_win_detect (
        .grid (grid),
        .sym  (mover_sym),
        .win  (mover_wins)
    );

    // Sequencer with all outputs registered; start overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state  <= S_IDLE;
            game_state <= GS_IDLE;
            whosTurn   <= 1'b1;
            mark       <= CELL_EMPTY;
            position   <= 4'd0;
            grid_clr   <= 1'b0;
            move_err   <= 1'b0;
            timeout    <= 1'b0;
            winner     <= CELL_EMPTY;
            timer      <= '0;
            settle_cnt <= '0;
        end else begin
            mark     <= CELL_EMPTY;
            grid_clr <= 1'b0;
            move_err <= 1'b0;
            timeout  <= 1'b0;

            if (start) begin
                // New game or restart; any move in flight is abandoned.
                fsm_state  <= S_WAIT;
                game_state <= GS_PLAY;
                whosTurn   <= 1'b1;
                grid_clr   <= 1'b1;
                winner     <= CELL_EMPTY;
                timer      <= '0;
                settle_cnt <= '0;
            end else begin
                case (fsm_state)
                    S_IDLE: begin
                    end

                    S_WAIT: begin
                        if (move_req && move_ok) begin
                            // A legal move beats a timer expiry in the same cycle.
                            mark       <= mover_sym;
                            position   <= move_pos;
                            settle_cnt <= '0;
                            fsm_state  <= S_SETTLE;
                        end else begin
                            if (move_req) begin
                                move_err <= 1'b1;
                            end
                            if (timer == TIMER_LAST) begin
                                timeout  <= 1'b1;
                                whosTurn <= ~whosTurn;
                                timer    <= '0;
                            end else if (timer != '1) begin
                                timer <= timer + TW'(1);
                            end
                        end
                    end

                    S_SETTLE: begin
                        // Give the recorder time to write the mark into grid.
                        if (settle_cnt == SETTLE_LAST) begin
                            fsm_state <= S_CHECK;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end

                    S_CHECK: begin
                        if (mover_wins) begin
                            winner     <= mover_sym;
                            game_state <= GS_OVER;
                            fsm_state  <= S_OVER;
                        end else begin
                            whosTurn  <= ~whosTurn;
                            timer     <= '0;
                            fsm_state <= S_WAIT;
                        end
                    end

                    S_OVER: begin
                    end

                    default: begin
                        fsm_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a table of single-move vectors plus
// hand-written sequences for reset, settle/turn hand-over, win, restart and
// timeout behaviour. Timeout shortened to 8 cycles.
module tb_turn_controller;
    import game_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        move_req;
    logic [3:0]  move_pos;
    logic [17:0] grid;
    logic [1:0]  game_state;
    logic        whosTurn;
    logic [1:0]  mark;
    logic [3:0]  position;
    logic        grid_clr;
    logic        move_err;
    logic        timeout;
    logic [1:0]  winner;
    fsm_state_t  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [17:0] grid;
        logic [3:0]  pos;
        logic [1:0]  exp_mark;
        logic        exp_err;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] last_pos;
    logic [3:0] exp_pos;

    turn_controller #(
        .TURN_TIMEOUT (TO),
        .TW           (4),
        .SETTLE_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_req   (move_req),
        .move_pos   (move_pos),
        .grid       (grid),
        .game_state (game_state),
        .whosTurn   (whosTurn),
        .mark       (mark),
        .position   (position),
        .grid_clr   (grid_clr),
        .move_err   (move_err),
        .timeout    (timeout),
        .winner     (winner),
        .fsm_state  (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gs"},       game_state, 2'b00);
        check({tag, "_turn"},     whosTurn,   1'b1);
        check({tag, "_mark"},     mark,       2'b00);
        check({tag, "_pos"},      position,   4'd0);
        check({tag, "_clr"},      grid_clr,   1'b0);
        check({tag, "_err"},      move_err,   1'b0);
        check({tag, "_timeout"},  timeout,    1'b0);
        check({tag, "_winner"},   winner,     2'b00);
        check({tag, "_state"},    fsm_state,  S_IDLE);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_clr"},    grid_clr,   1'b1);
        check({tag, "_gs"},     game_state, 2'b01);
        check({tag, "_turn"},   whosTurn,   1'b1);
        check({tag, "_winner"}, winner,     2'b00);
    endtask

    task automatic do_move(input logic [3:0] pos);
        move_pos = pos;
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"v_empty_c0",   18'h00000, 4'd0,  2'b10, 1'b0};
        vecs[1] = '{"v_empty_c8",   18'h00000, 4'd8,  2'b10, 1'b0};
        vecs[2] = '{"v_x_on_c8",    18'h20000, 4'd8,  2'b00, 1'b1};
        vecs[3] = '{"v_o_on_c3",    18'h00040, 4'd3,  2'b00, 1'b1};
        vecs[4] = '{"v_pos9",       18'h00000, 4'd9,  2'b00, 1'b1};
        vecs[5] = '{"v_pos15",      18'h00000, 4'd15, 2'b00, 1'b1};
        vecs[6] = '{"v_last_free5", 18'h2A2AA, 4'd5,  2'b10, 1'b0};
        vecs[7] = '{"v_o_c0_mv1",   18'h00001, 4'd1,  2'b10, 1'b0};

        rst = 1'b1; start = 1'b0; move_req = 1'b0; move_pos = 4'd0; grid = 18'h0;
        ticks(2);
        check_reset_values("rst");
        rst = 1'b0;
        tick();

        // Reset while settling clears everything immediately.
        do_start("t1_start");
        do_move(4'd6);
        check("t1_mark", mark, 2'b10);
        tick();
        check("t1_in_settle", fsm_state, S_SETTLE);
        rst = 1'b1;
        #2;
        check_reset_values("t1_async");
        tick();
        rst = 1'b0;
        tick();
        check_reset_values("t1_after");
        do_start("t1_restart");

        // X plays the centre; turn passes after settle + check.
        do_move(4'd4);
        check("t2_mark", mark, 2'b10);
        check("t2_pos", position, 4'd4);
        tick();
        check("t2_mark_gone", mark, 2'b00);
        check("t2_pos_held", position, 4'd4);
        grid = 18'h00200;
        tick();
        check("t2_turn_in_check", whosTurn, 1'b1);
        tick();
        check("t2_turn_passed", whosTurn, 1'b0);
        check("t2_state_wait", fsm_state, S_WAIT);

        // Occupied and off-board requests are rejected without a mark.
        do_move(4'd4);
        check("t3_err_occ", move_err, 1'b1);
        check("t3_mark_occ", mark, 2'b00);
        check("t3_turn_occ", whosTurn, 1'b0);
        tick();
        check("t3_err_clear", move_err, 1'b0);
        do_move(4'd9);
        check("t3_err_9", move_err, 1'b1);
        check("t3_mark_9", mark, 2'b00);
        check("t3_turn_9", whosTurn, 1'b0);
        check("t3_pos_held", position, 4'd4);

        // Table of single moves from a fresh game (X to move).
        last_pos = 4'd4;
        for (int i = 0; i < 8; i++) begin
            do_start({vecs[i].name, "_st"});
            grid = vecs[i].grid;
            do_move(vecs[i].pos);
            exp_pos = (vecs[i].exp_mark != 2'b00) ? vecs[i].pos : last_pos;
            check({vecs[i].name, "_mark"}, mark, vecs[i].exp_mark);
            check({vecs[i].name, "_err"}, move_err, vecs[i].exp_err);
            check({vecs[i].name, "_pos"}, position, exp_pos);
            last_pos = exp_pos;
        end

        // An existing O line is not credited while X moves.
        do_start("mo_start");
        grid = 18'h00540;
        do_move(4'd0);
        check("mo_mark", mark, 2'b10);
        grid = 18'h00542;
        ticks(3);
        check("mo_winner", winner, 2'b00);
        check("mo_gs", game_state, 2'b01);
        check("mo_turn", whosTurn, 1'b0);

        // X completes the top row.
        do_start("t4_start");
        grid = 18'h0000A;
        do_move(4'd2);
        check("t4_mark", mark, 2'b10);
        check("t4_pos", position, 4'd2);
        grid = 18'h0002A;
        ticks(2);
        check("t4_winner_pending", winner, 2'b00);
        tick();
        check("t4_winner", winner, 2'b10);
        check("t4_gs", game_state, 2'b10);
        check("t4_state", fsm_state, S_OVER);
        do_move(4'd5);
        check("t4_over_mark", mark, 2'b00);
        check("t4_over_err", move_err, 1'b0);
        check("t4_over_winner", winner, 2'b10);
        check("t4_over_turn", whosTurn, 1'b1);

        // Restart from OVER, then restart during WAIT with a move pending.
        grid = 18'h0;
        do_start("t6_over");
        check("t6_over_state", fsm_state, S_WAIT);
        tick();
        start = 1'b1;
        move_pos = 4'd0;
        move_req = 1'b1;
        tick();
        start = 1'b0;
        move_req = 1'b0;
        check("t6_wait_clr", grid_clr, 1'b1);
        check("t6_wait_mark", mark, 2'b00);
        check("t6_wait_turn", whosTurn, 1'b1);
        check("t6_wait_gs", game_state, 2'b01);
        check("t6_wait_state", fsm_state, S_WAIT);

        // Turn timer: expiry on the 8th cycle, then a move on the expiry cycle.
        do_start("t5_start");
        ticks(TO - 1);
        check("t5_no_to_yet", timeout, 1'b0);
        check("t5_turn_before", whosTurn, 1'b1);
        tick();
        check("t5_timeout", timeout, 1'b1);
        check("t5_turn_after", whosTurn, 1'b0);
        check("t5_to_no_mark", mark, 2'b00);
        tick();
        check("t5_timeout_pulse", timeout, 1'b0);
        ticks(TO - 2);
        check("t5_no_to_2", timeout, 1'b0);
        do_move(4'd0);
        check("t5_move_mark", mark, 2'b01);
        check("t5_move_no_to", timeout, 1'b0);
        check("t5_move_turn", whosTurn, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
